// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a 2-entry skid buffer, global hold, flush,
// occupancy reporting and a saturating back-pressure counter.
module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              le,
    input  logic              FlushIn,
    input  logic              ValidIn,
    output logic              ReadyOut,
    input  logic [DATA_W-1:0] DataIn,
    output logic              ValidOut,
    input  logic              ReadyIn,
    output logic [DATA_W-1:0] DataOut,
    output logic [1:0]        Occupancy,
    output logic [CNT_W-1:0]  StallCount
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    state_t            stateNext;
    logic [DATA_W-1:0] mainP0;
    logic [DATA_W-1:0] skidP0;
    logic              acc;
    logic              rel;
    logic              loadMainIn;
    logic              loadMainSkid;
    logic              loadSkid;
    logic              stallEvt;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // ReadyOut depends only on registered state and le, never on ValidIn/ReadyIn.
    assign ReadyOut = (state != FULL) & le;
    assign ValidOut = (state != EMPTY);
    assign DataOut  = mainP0;
    assign acc      = ValidIn & ReadyOut;
    assign rel      = ValidOut & ReadyIn & le;
    assign stallEvt = le & ~FlushIn & ValidOut & ~ReadyIn;

    always_comb begin
        case (state)
            ONE:     Occupancy = 2'd1;
            FULL:    Occupancy = 2'd2;
            default: Occupancy = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= stateNext;
        end
    end

    // Flush wins over the hold so a squash is never lost while the stage is frozen.
    always_comb begin
        stateNext    = state;
        loadMainIn   = 1'b0;
        loadMainSkid = 1'b0;
        loadSkid     = 1'b0;
        if (FlushIn) begin
            stateNext = EMPTY;
        end else if (le) begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        stateNext  = ONE;
                        loadMainIn = 1'b1;
                    end
                end
                ONE: begin
                    if (acc && rel) begin
                        loadMainIn = 1'b1;
                    end else if (acc) begin
                        stateNext = FULL;
                        loadSkid  = 1'b1;
                    end else if (rel) begin
                        stateNext = EMPTY;
                    end
                end
                FULL: begin
                    if (rel) begin
                        stateNext    = ONE;
                        loadMainSkid = 1'b1;
                    end
                end
                default: stateNext = EMPTY;
            endcase
        end
    end

    // ---- data stage p0: main (output) and skid registers ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mainP0 <= '0;
            skidP0 <= '0;
        end else begin
            if (loadMainIn) begin
                mainP0 <= DataIn;
            end else if (loadMainSkid) begin
                mainP0 <= skidP0;
            end
            if (loadSkid) begin
                skidP0 <= DataIn;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            StallCount <= '0;
        end else if (stallEvt) begin
            StallCount <= satInc(StallCount);
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: queue scoreboard on released beats plus
// point checks; a CNT_W=3 copy shares all inputs to exercise saturation.
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        le;
    logic        FlushIn;
    logic        ValidIn;
    logic [31:0] DataIn;
    logic        ReadyIn;

    logic        ReadyOut, ValidOut;
    logic [31:0] DataOut;
    logic [1:0]  Occupancy;
    logic [15:0] StallCount;

    logic        ReadyOut3, ValidOut3;
    logic [31:0] DataOut3;
    logic [1:0]  Occupancy3;
    logic [2:0]  StallCount3;

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] expQ[$];

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .le(le), .FlushIn(FlushIn),
        .ValidIn(ValidIn), .ReadyOut(ReadyOut), .DataIn(DataIn),
        .ValidOut(ValidOut), .ReadyIn(ReadyIn), .DataOut(DataOut),
        .Occupancy(Occupancy), .StallCount(StallCount)
    );

    pipe_stage_skid #(.DATA_W(32), .CNT_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .le(le), .FlushIn(FlushIn),
        .ValidIn(ValidIn), .ReadyOut(ReadyOut3), .DataIn(DataIn),
        .ValidOut(ValidOut3), .ReadyIn(ReadyIn), .DataOut(DataOut3),
        .Occupancy(Occupancy3), .StallCount(StallCount3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a transfer happens at the next edge whenever these terms hold.
    always @(negedge clk) begin
        if (rst_n && le && !FlushIn && ValidOut && ReadyIn) begin
            compared++;
            if (expQ.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_beat: got 0x%0h expected none", DataOut);
            end else begin
                logic [31:0] e;
                e = expQ.pop_front();
                if (DataOut !== e) begin
                    mismatched++;
                    $display("FAIL beat_order: got 0x%0h expected 0x%0h", DataOut, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; le = 1'b1; FlushIn = 1'b0;
        ValidIn = 1'b1; DataIn = 32'hDEADBEEF; ReadyIn = 1'b0;
        step();
        step();
        check("rst_validout", 32'(ValidOut), 32'd0);
        check("rst_dataout", DataOut, 32'd0);
        check("rst_occupancy", 32'(Occupancy), 32'd0);
        check("rst_stall", 32'(StallCount), 32'd0);
        rst_n = 1'b1; ValidIn = 1'b0;
        check("rst_readyout", 32'(ReadyOut), 32'd1);

        // Streaming
        ReadyIn = 1'b1;
        for (int i = 1; i <= 8; i++) expQ.push_back(32'(i));
        for (int i = 1; i <= 8; i++) begin
            ValidIn = 1'b1; DataIn = 32'(i);
            check("stream_ready", 32'(ReadyOut), 32'd1);
            step();
            check("stream_data", DataOut, 32'(i));
        end
        ValidIn = 1'b0;
        step();
        check("stream_drained", 32'(ValidOut), 32'd0);

        // Backpressure
        ReadyIn = 1'b0;
        expQ.push_back(32'hA); expQ.push_back(32'hB); expQ.push_back(32'hC);
        ValidIn = 1'b1; DataIn = 32'hA; step();
        DataIn = 32'hB; step();
        DataIn = 32'hC; step();
        check("bp_occupancy", 32'(Occupancy), 32'd2);
        check("bp_readyout", 32'(ReadyOut), 32'd0);
        check("bp_head", DataOut, 32'hA);
        check("bp_stall", 32'(StallCount), 32'd2);
        ReadyIn = 1'b1; step();
        check("bp_skid_to_main", DataOut, 32'hB);
        check("bp_ready_rise", 32'(ReadyOut), 32'd1);
        step();
        check("bp_last", DataOut, 32'hC);
        ValidIn = 1'b0; step();
        check("bp_empty", 32'(Occupancy), 32'd0);
        check("bp_queue_empty", 32'(expQ.size()), 32'd0);

        // Flush while FULL with a beat presented on the same edge
        ReadyIn = 1'b0;
        ValidIn = 1'b1; DataIn = 32'hA; step();
        DataIn = 32'hB; step();
        check("fl_full", 32'(Occupancy), 32'd2);
        FlushIn = 1'b1; DataIn = 32'hC; step();
        check("fl_validout", 32'(ValidOut), 32'd0);
        check("fl_occupancy", 32'(Occupancy), 32'd0);
        check("fl_stall", 32'(StallCount), 32'd3);
        FlushIn = 1'b0; ValidIn = 1'b0; ReadyIn = 1'b1;
        repeat (3) step();
        check("fl_no_ghost", 32'(ValidOut), 32'd0);

        // Hold
        ReadyIn = 1'b0;
        expQ.push_back(32'h55);
        ValidIn = 1'b1; DataIn = 32'h55; step();
        le = 1'b0; ReadyIn = 1'b1; DataIn = 32'h66;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_data", DataOut, 32'h55);
            check("hold_occupancy", 32'(Occupancy), 32'd1);
            check("hold_readyout", 32'(ReadyOut), 32'd0);
            check("hold_stall", 32'(StallCount), 32'd3);
        end
        expQ.push_back(32'h66);
        le = 1'b1; step();
        check("hold_resume", DataOut, 32'h66);
        ValidIn = 1'b0; step();
        check("hold_drained", 32'(ValidOut), 32'd0);

        // Flush overrides hold
        ReadyIn = 1'b0;
        ValidIn = 1'b1; DataIn = 32'h77; step();
        ValidIn = 1'b0; le = 1'b0; FlushIn = 1'b1; step();
        check("flhold_validout", 32'(ValidOut), 32'd0);
        le = 1'b1; FlushIn = 1'b0;

        // Counter saturation
        rst_n = 1'b0; step();
        rst_n = 1'b1;
        check("sat_rst", 32'(StallCount3), 32'd0);
        ValidIn = 1'b1; DataIn = 32'h99; step();
        ValidIn = 1'b0;
        repeat (7) step();
        check("sat_reach7", 32'(StallCount3), 32'd7);
        repeat (3) step();
        check("sat_hold7", 32'(StallCount3), 32'd7);
        check("sat_wide10", 32'(StallCount), 32'd10);
        FlushIn = 1'b1; step();
        FlushIn = 1'b0;
        check("sat_flush_keep", 32'(StallCount3), 32'd7);
        check("sat_flush_valid", 32'(ValidOut3), 32'd0);
        rst_n = 1'b0; step();
        rst_n = 1'b1;
        check("sat_rst_clear", 32'(StallCount3), 32'd0);

        check("final_queue_empty", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
